hazard_ctrl_mp: RTL and testbench

Parametrised pipeline hazard and flow controller for the in-order core, sitting between decode (IF/ID), execute (ID/EX) and the data-memory interface. It detects load-use hazards against N decode read ports with a configurable load-to-use latency. It also freezes the whole pipeline while data memory is busy, and holds single-cycle redirect requests that arrive during a freeze until the freeze releases. It generalises the two-port, single-cycle-latency controller with a pending-load scoreboard and a small state machine.

---
 rtl/hazard_ctrl_mp.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl_mp.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mp.sv
// Load-use hazard, memory-freeze and redirect controller with a pending-load scoreboard.
// Optional perf counters are built when CTRL_PERF_CNT_EN is defined.
module hazard_ctrl_mp #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD_PORTS   = 2,
    parameter int unsigned LOAD_LATENCY   = 1,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   id_ex_mem_data_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0]              id_ex_reg_wr_addr,
    input  logic [NUM_RD_PORTS-1:0]                if_id_rd_reg_en,
    input  logic [NUM_RD_PORTS*REG_ADDR_WIDTH-1:0] if_id_rd_reg_addr,
    input  logic                                   select_new_pc,
    input  logic                                   mem_busy,
    output logic                                   inst_rd_en,
    output logic                                   stall,
    output logic                                   freeze,
    output logic                                   general_flush,
    output logic                                   decode_flush,
    output logic [CNT_WIDTH-1:0]                   stall_cnt,
    output logic [CNT_WIDTH-1:0]                   freeze_cnt,
    output logic [CNT_WIDTH-1:0]                   flush_cnt
);

    localparam int unsigned SbDepth = (LOAD_LATENCY > 1) ? LOAD_LATENCY - 1 : 1;

    typedef enum logic {StRun, StMemWait} state_t;

    state_t state_q, state_d;
    logic   redirect_pending_q, redirect_pending_d;
    logic   stall_bubble_q;
    logic   load_hazard;
    logic   redirect;

    logic [SbDepth-1:0]                     sb_valid_q;
    logic [SbDepth-1:0][REG_ADDR_WIDTH-1:0] sb_addr_q;

    // Scoreboard of loads that have left EX but are not yet forwardable.
    generate
        if (LOAD_LATENCY > 1) begin : g_sb
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sb_valid_q <= '0;
                    sb_addr_q  <= '0;
                end else if (!mem_busy) begin
                    sb_valid_q[0] <= id_ex_mem_data_rd_en & ~stall_bubble_q;
                    sb_addr_q[0]  <= id_ex_reg_wr_addr;
                    for (int k = 1; k < SbDepth; k++) begin
                        sb_valid_q[k] <= sb_valid_q[k-1];
                        sb_addr_q[k]  <= sb_addr_q[k-1];
                    end
                end
            end
        end else begin : g_no_sb
            assign sb_valid_q = '0;
            assign sb_addr_q  = '0;
        end
    endgenerate

    // EX holds a bubble in the cycle after a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_bubble_q <= 1'b0;
        end else if (!mem_busy) begin
            stall_bubble_q <= stall;
        end
    end

    always_comb begin
        load_hazard = 1'b0;
        for (int i = 0; i < NUM_RD_PORTS; i++) begin
            if (if_id_rd_reg_en[i]) begin
                if (id_ex_mem_data_rd_en &&
                    id_ex_reg_wr_addr == if_id_rd_reg_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) begin
                    load_hazard = 1'b1;
                end
                for (int k = 0; k < SbDepth; k++) begin
                    if (sb_valid_q[k] &&
                        sb_addr_q[k] == if_id_rd_reg_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]) begin
                        load_hazard = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= StRun;
            redirect_pending_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            redirect_pending_q <= redirect_pending_d;
        end
    end

    always_comb begin
        state_d            = mem_busy ? StMemWait : StRun;
        redirect_pending_d = 1'b0;
        unique case (state_q)
            StRun:     if (mem_busy) redirect_pending_d = select_new_pc;
            StMemWait: if (mem_busy) redirect_pending_d = redirect_pending_q | select_new_pc;
            default:   redirect_pending_d = 1'b0;
        endcase
    end

    // A held redirect is replayed on the release cycle only.
    assign redirect = select_new_pc | redirect_pending_q;

    always_comb begin
        inst_rd_en    = 1'b1;
        stall         = 1'b0;
        freeze        = 1'b0;
        general_flush = 1'b0;
        decode_flush  = 1'b0;
        if (rst) begin
            inst_rd_en    = 1'b0;
            general_flush = 1'b1;
            decode_flush  = 1'b1;
        end else if (mem_busy) begin
            inst_rd_en = 1'b0;
            freeze     = 1'b1;
        end else if (redirect) begin
            general_flush = 1'b1;
            decode_flush  = 1'b1;
        end else if (load_hazard) begin
            inst_rd_en   = 1'b0;
            stall        = 1'b1;
            decode_flush = 1'b1;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            freeze_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (stall && stall_cnt != '1)          stall_cnt  <= stall_cnt + 1'b1;
            if (freeze && freeze_cnt != '1)        freeze_cnt <= freeze_cnt + 1'b1;
            if (general_flush && flush_cnt != '1)  flush_cnt  <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt  = '0;
    assign freeze_cnt = '0;
    assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mp.sv
// Directed bench for hazard_ctrl_mp at LOAD_LATENCY 1, 3 and 2.
// Output vectors are packed as {inst_rd_en, stall, freeze, general_flush, decode_flush}.
module tb_hazard_ctrl_mp;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    // DUT a: LOAD_LATENCY=1, 2 ports
    logic        a_ld, a_sel, a_busy;
    logic [4:0]  a_wa;
    logic [1:0]  a_en;
    logic [9:0]  a_ra;
    logic        a_ird, a_stall, a_frz, a_gf, a_df;
    logic [31:0] a_sc, a_fc, a_flc;
    logic [4:0]  a_out;
    assign a_out = {a_ird, a_stall, a_frz, a_gf, a_df};

    // DUT b: LOAD_LATENCY=3, 3 ports
    logic        b_ld, b_sel, b_busy;
    logic [4:0]  b_wa;
    logic [2:0]  b_en;
    logic [14:0] b_ra;
    logic        b_ird, b_stall, b_frz, b_gf, b_df;
    logic [31:0] b_sc, b_fc, b_flc;
    logic [4:0]  b_out;
    assign b_out = {b_ird, b_stall, b_frz, b_gf, b_df};

    // DUT c: LOAD_LATENCY=2, 2 ports
    logic        c_ld, c_sel, c_busy;
    logic [4:0]  c_wa;
    logic [1:0]  c_en;
    logic [9:0]  c_ra;
    logic        c_ird, c_stall, c_frz, c_gf, c_df;
    logic [31:0] c_sc, c_fc, c_flc;
    logic [4:0]  c_out;
    assign c_out = {c_ird, c_stall, c_frz, c_gf, c_df};

    hazard_ctrl_mp #(.REG_ADDR_WIDTH(5), .NUM_RD_PORTS(2), .LOAD_LATENCY(1), .CNT_WIDTH(32)) u_a (
        .clk(clk), .rst(rst), .id_ex_mem_data_rd_en(a_ld), .id_ex_reg_wr_addr(a_wa),
        .if_id_rd_reg_en(a_en), .if_id_rd_reg_addr(a_ra), .select_new_pc(a_sel),
        .mem_busy(a_busy), .inst_rd_en(a_ird), .stall(a_stall), .freeze(a_frz),
        .general_flush(a_gf), .decode_flush(a_df), .stall_cnt(a_sc), .freeze_cnt(a_fc),
        .flush_cnt(a_flc)
    );

    hazard_ctrl_mp #(.REG_ADDR_WIDTH(5), .NUM_RD_PORTS(3), .LOAD_LATENCY(3), .CNT_WIDTH(32)) u_b (
        .clk(clk), .rst(rst), .id_ex_mem_data_rd_en(b_ld), .id_ex_reg_wr_addr(b_wa),
        .if_id_rd_reg_en(b_en), .if_id_rd_reg_addr(b_ra), .select_new_pc(b_sel),
        .mem_busy(b_busy), .inst_rd_en(b_ird), .stall(b_stall), .freeze(b_frz),
        .general_flush(b_gf), .decode_flush(b_df), .stall_cnt(b_sc), .freeze_cnt(b_fc),
        .flush_cnt(b_flc)
    );

    hazard_ctrl_mp #(.REG_ADDR_WIDTH(5), .NUM_RD_PORTS(2), .LOAD_LATENCY(2), .CNT_WIDTH(32)) u_c (
        .clk(clk), .rst(rst), .id_ex_mem_data_rd_en(c_ld), .id_ex_reg_wr_addr(c_wa),
        .if_id_rd_reg_en(c_en), .if_id_rd_reg_addr(c_ra), .select_new_pc(c_sel),
        .mem_busy(c_busy), .inst_rd_en(c_ird), .stall(c_stall), .freeze(c_frz),
        .general_flush(c_gf), .decode_flush(c_df), .stall_cnt(c_sc), .freeze_cnt(c_fc),
        .flush_cnt(c_flc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        a_ld = 0; a_sel = 0; a_busy = 0; a_wa = '0; a_en = '0; a_ra = '0;
        b_ld = 0; b_sel = 0; b_busy = 0; b_wa = '0; b_en = '0; b_ra = '0;
        c_ld = 0; c_sel = 0; c_busy = 0; c_wa = '0; c_en = '0; c_ra = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        a_busy = 1'b1;
        #2;
        total_cnt++;
        if (a_out !== 5'b00011) $display("FAIL reset_a: got %b want %b", a_out, 5'b00011);
        else pass_cnt++;
        total_cnt++;
        if (b_out !== 5'b00011) $display("FAIL reset_b: got %b want %b", b_out, 5'b00011);
        else pass_cnt++;
        total_cnt++;
        if (a_sc !== 32'd0 || a_fc !== 32'd0 || a_flc !== 32'd0)
            $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", a_sc, a_fc, a_flc);
        else pass_cnt++;
        step();
        rst = 1'b0;
        a_busy = 1'b0;
    endtask

    task automatic test_lat1();
        a_ld = 1; a_wa = 5'd5; a_en = 2'b10; a_ra = {5'd5, 5'd0};
        #1;
        total_cnt++;
        if (a_out !== 5'b01001) $display("FAIL lat1_stall: got %b want %b", a_out, 5'b01001);
        else pass_cnt++;
        step();
        a_ld = 0;
        #1;
        total_cnt++;
        if (a_out !== 5'b10000) $display("FAIL lat1_bubble: got %b want %b", a_out, 5'b10000);
        else pass_cnt++;
        step();
        a_ld = 1; a_wa = 5'd0; a_en = 2'b01; a_ra = {5'd5, 5'd0};
        #1;
        total_cnt++;
        if (a_out !== 5'b01001) $display("FAIL lat1_r0: got %b want %b", a_out, 5'b01001);
        else pass_cnt++;
        step();
        idle();
        #1;
        total_cnt++;
        if (a_out !== 5'b10000) $display("FAIL lat1_idle: got %b want %b", a_out, 5'b10000);
        else pass_cnt++;
    endtask

    task automatic test_lat3();
        logic [4:0] exp_tbl [4];
        exp_tbl[0] = 5'b01001; exp_tbl[1] = 5'b01001; exp_tbl[2] = 5'b01001; exp_tbl[3] = 5'b10000;
        step();
        b_ld = 1; b_wa = 5'd7; b_en = 3'b100; b_ra = {5'd7, 5'd1, 5'd2};
        for (int c = 0; c < 4; c++) begin
            #1;
            total_cnt++;
            if (b_out !== exp_tbl[c]) $display("FAIL lat3_cyc%0d: got %b want %b", c, b_out, exp_tbl[c]);
            else pass_cnt++;
            step();
            b_ld = 0;
        end
        b_ld = 1; b_wa = 5'd7; b_en = 3'b001; b_ra = {5'd7, 5'd1, 5'd3};
        for (int c = 0; c < 4; c++) begin
            #1;
            total_cnt++;
            if (b_out !== 5'b10000) $display("FAIL lat3_noen%0d: got %b want %b", c, b_out, 5'b10000);
            else pass_cnt++;
            step();
            b_ld = 0;
        end
        idle();
    endtask

    task automatic test_redirect_hazard();
        step();
        a_ld = 1; a_wa = 5'd5; a_en = 2'b10; a_ra = {5'd5, 5'd0}; a_sel = 1;
        #1;
        total_cnt++;
        if (a_out !== 5'b10011) $display("FAIL redir_hazard: got %b want %b", a_out, 5'b10011);
        else pass_cnt++;
        step();
        idle();
    endtask

    task automatic test_mem_wait();
        step();
        for (int c = 0; c < 4; c++) begin
            a_busy = 1'b1;
            a_sel  = (c == 1);
            #1;
            total_cnt++;
            if (a_out !== 5'b00100) $display("FAIL memwait_cyc%0d: got %b want %b", c, a_out, 5'b00100);
            else pass_cnt++;
            step();
        end
        a_busy = 0; a_sel = 0;
        #1;
        total_cnt++;
        if (a_out !== 5'b10011) $display("FAIL memwait_release: got %b want %b", a_out, 5'b10011);
        else pass_cnt++;
        step();
        #1;
        total_cnt++;
        if (a_out !== 5'b10000) $display("FAIL memwait_after: got %b want %b", a_out, 5'b10000);
        else pass_cnt++;
    endtask

    task automatic test_freeze_sb();
        logic [4:0] exp_tbl [5];
        exp_tbl[0] = 5'b01001; exp_tbl[1] = 5'b00100; exp_tbl[2] = 5'b00100;
        exp_tbl[3] = 5'b01001; exp_tbl[4] = 5'b10000;
        step();
        c_en = 2'b01; c_ra = {5'd1, 5'd9};
        for (int c = 0; c < 5; c++) begin
            c_ld   = (c == 0);
            c_wa   = 5'd9;
            c_busy = (c == 1) || (c == 2);
            #1;
            total_cnt++;
            if (c_out !== exp_tbl[c]) $display("FAIL freeze_sb_cyc%0d: got %b want %b", c, c_out, exp_tbl[c]);
            else pass_cnt++;
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        step();
        a_busy = 1; a_sel = 1;
        #1;
        total_cnt++;
        if (a_out !== 5'b00100) $display("FAIL rstmid_freeze: got %b want %b", a_out, 5'b00100);
        else pass_cnt++;
        step();
        a_sel = 0;
        #1;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (a_out !== 5'b00011) $display("FAIL rstmid_async: got %b want %b", a_out, 5'b00011);
        else pass_cnt++;
        step();
        rst = 1'b0;
        a_busy = 0;
        #1;
        total_cnt++;
        if (a_out !== 5'b10000) $display("FAIL rstmid_after: got %b want %b", a_out, 5'b10000);
        else pass_cnt++;
        total_cnt++;
        if (a_sc !== 32'd0 || a_fc !== 32'd0 || a_flc !== 32'd0)
            $display("FAIL rstmid_cnt: got %0d %0d %0d want 0 0 0", a_sc, a_fc, a_flc);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst = 1'b1;
        idle();
        test_reset();
        test_lat1();
        test_lat3();
        test_redirect_hazard();
        test_mem_wait();
        test_freeze_sb();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
